// File: rtl/rf_tr_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// rf_tr_sequencer_pkg
// Shared definitions for the RF T/R sequencing blocks in the xpu:
//   - DLY_W : width of the lead/lag/settle delay configuration and counter
//   - ST_W  : width of the exported sequencer state
//   - ST_*  : sequencer state encodings (fixed values, visible on the state port)
//   - WD_W  : width of the TX watchdog limit/counter
// ----------------------------------------------------------------------------
package rf_tr_sequencer_pkg;

  localparam int DLY_W = 10;
  localparam int ST_W  = 3;
  localparam int WD_W  = 16;

  typedef logic [DLY_W-1:0] dly_t;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_LEAD   = 3'd1;
  localparam logic [ST_W-1:0] ST_GRANT  = 3'd2;
  localparam logic [ST_W-1:0] ST_TX     = 3'd3;
  localparam logic [ST_W-1:0] ST_LAG    = 3'd4;
  localparam logic [ST_W-1:0] ST_SETTLE = 3'd5;

  // T/R switch sits on the TX side from LEAD through LAG.
  function automatic logic st_tr_sw_tx(input logic [ST_W-1:0] st);
    return (st == ST_LEAD) || (st == ST_GRANT) || (st == ST_TX) || (st == ST_LAG);
  endfunction

  // PA is powered from GRANT through LAG.
  function automatic logic st_pa_en(input logic [ST_W-1:0] st);
    return (st == ST_GRANT) || (st == ST_TX) || (st == ST_LAG);
  endfunction

endpackage

// File: rtl/rf_tr_sequencer_watchdog.sv
// ----------------------------------------------------------------------------
// rf_tr_sequencer_watchdog
// TX duration watchdog, only present when RF_TX_WATCHDOG_EN is defined.
// Ports:
//   clk, rstn      : clock, synchronous active-low reset
//   tx_entry       : 1 on the cycle the sequencer is about to enter TX
//   in_tx          : 1 while the sequencer is in TX
//   cfg_tx_max     : TX limit in cycles, 0 disables the watchdog
//   expire         : 1 on the last allowed TX cycle (sequencer leaves TX next)
// ----------------------------------------------------------------------------
`ifdef RF_TX_WATCHDOG_EN
module rf_tr_sequencer_watchdog
  import rf_tr_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            tx_entry,
  input  logic            in_tx,
  input  logic [WD_W-1:0] cfg_tx_max,
  output logic            expire
);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  // Counter holds the number of TX cycles already completed; saturates so a
  // disabled watchdog never wraps into a false match.
  always_comb begin
    cnt_d = cnt_q;
    if (tx_entry) begin
      cnt_d = '0;
    end else if (in_tx && (cnt_q != {WD_W{1'b1}})) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cfg_tx_max-th TX cycle is the last one, so TX lasts exactly cfg_tx_max cycles.
  assign expire = in_tx && (cfg_tx_max != '0) && (cnt_q == cfg_tx_max - 16'd1);

endmodule
`endif

// File: rtl/rf_tr_sequencer.sv
// ----------------------------------------------------------------------------
// rf_tr_sequencer
// Sequences T/R switch, PA enable and RX blanking around a baseband transmit.
// IDLE -> LEAD -> GRANT -> TX -> LAG -> SETTLE -> IDLE, with abort from
// LEAD/GRANT to SETTLE when tx_req drops. All outputs are registered and
// always reflect the state currently held in the state register.
// Optional feature: define RF_TX_WATCHDOG_EN to add a TX duration watchdog
// (cfg_tx_max, wd_abort); without it wd_abort is tied 0.
// Ports:
//   clk, rstn                       : clock, synchronous active-low reset
//   tx_req                          : level request from TX control FSM
//   tx_bb_is_ongoing                : baseband TX active (level)
//   pulse_tx_bb_end                 : one-cycle end of baseband TX
//   cfg_pa_lead/cfg_pa_lag/cfg_rx_settle : delays, sampled on state entry
//   cfg_tx_max                      : watchdog limit (watchdog build only)
//   tx_grant, tr_sw_tx, pa_en, rx_blank, busy, state, wd_abort : outputs
// ----------------------------------------------------------------------------
module rf_tr_sequencer
  import rf_tr_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             tx_req,
  input  logic             tx_bb_is_ongoing,
  input  logic             pulse_tx_bb_end,
  input  logic [DLY_W-1:0] cfg_pa_lead,
  input  logic [DLY_W-1:0] cfg_pa_lag,
  input  logic [DLY_W-1:0] cfg_rx_settle,
  input  logic [WD_W-1:0]  cfg_tx_max,
  output logic             tx_grant,
  output logic             tr_sw_tx,
  output logic             pa_en,
  output logic             rx_blank,
  output logic             busy,
  output logic [ST_W-1:0]  state,
  output logic             wd_abort
);

  logic [ST_W-1:0] state_q, state_d;
  dly_t            cnt_q, cnt_d;
  logic            tx_grant_q, tx_grant_d;
  logic            tr_sw_tx_q, tr_sw_tx_d;
  logic            pa_en_q, pa_en_d;
  logic            rx_blank_q, rx_blank_d;
  logic            busy_q, busy_d;
  logic            wd_abort_q, wd_abort_d;
  logic            wd_expire;

`ifdef RF_TX_WATCHDOG_EN
  rf_tr_sequencer_watchdog u_watchdog (
    .clk        (clk),
    .rstn       (rstn),
    .tx_entry   ((state_d == ST_TX) && (state_q != ST_TX)),
    .in_tx      (state_q == ST_TX),
    .cfg_tx_max (cfg_tx_max),
    .expire     (wd_expire)
  );
`else
  logic unused_cfg_tx_max;
  assign unused_cfg_tx_max = ^cfg_tx_max;
  assign wd_expire         = 1'b0;
`endif

  // Timed states load the counter on entry and leave when it reaches zero,
  // so a state lasts cfg+1 cycles and later cfg changes have no effect.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - dly_t'(1) : cnt_q;
    wd_abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_req) begin
          state_d = ST_LEAD;
          cnt_d   = cfg_pa_lead;
        end
      end
      ST_LEAD: begin
        if (!tx_req) begin
          state_d = ST_SETTLE;
          cnt_d   = cfg_rx_settle;
        end else if (cnt_q == '0) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Baseband already started: it must be followed through even if the
        // request drops in the same cycle.
        if (tx_bb_is_ongoing) begin
          state_d = ST_TX;
        end else if (!tx_req) begin
          state_d = ST_SETTLE;
          cnt_d   = cfg_rx_settle;
        end
      end
      ST_TX: begin
        if (pulse_tx_bb_end) begin
          state_d = ST_LAG;
          cnt_d   = cfg_pa_lag;
        end else if (wd_expire) begin
          state_d    = ST_LAG;
          cnt_d      = cfg_pa_lag;
          wd_abort_d = 1'b1;
        end
      end
      ST_LAG: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = cfg_rx_settle;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with state_q on every cycle.
    tx_grant_d = (state_d == ST_GRANT);
    tr_sw_tx_d = st_tr_sw_tx(state_d);
    pa_en_d    = st_pa_en(state_d);
    rx_blank_d = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_grant_q <= 1'b0;
      tr_sw_tx_q <= 1'b0;
      pa_en_q    <= 1'b0;
      rx_blank_q <= 1'b0;
      busy_q     <= 1'b0;
      wd_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_grant_q <= tx_grant_d;
      tr_sw_tx_q <= tr_sw_tx_d;
      pa_en_q    <= pa_en_d;
      rx_blank_q <= rx_blank_d;
      busy_q     <= busy_d;
      wd_abort_q <= wd_abort_d;
    end
  end

  assign state    = state_q;
  assign tx_grant = tx_grant_q;
  assign tr_sw_tx = tr_sw_tx_q;
  assign pa_en    = pa_en_q;
  assign rx_blank = rx_blank_q;
  assign busy     = busy_q;
  assign wd_abort = wd_abort_q;

endmodule

// File: tb/tb_rf_tr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rf_tr_sequencer
// Bench for rf_tr_sequencer: directed scenarios followed by randomized
// traffic, checked every cycle against a phase/duration model. Build with
// RF_TX_WATCHDOG_EN defined to exercise the watchdog variant.
// ----------------------------------------------------------------------------
module tb_rf_tr_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tx_req;
  logic        tx_bb_is_ongoing;
  logic        pulse_tx_bb_end;
  logic [9:0]  cfg_pa_lead;
  logic [9:0]  cfg_pa_lag;
  logic [9:0]  cfg_rx_settle;
  logic [15:0] cfg_tx_max;
  logic        tx_grant;
  logic        tr_sw_tx;
  logic        pa_en;
  logic        rx_blank;
  logic        busy;
  logic [2:0]  state;
  logic        wd_abort;

`ifdef RF_TX_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  always #5 clk = ~clk;

  rf_tr_sequencer dut (
    .clk              (clk),
    .rstn             (rstn),
    .tx_req           (tx_req),
    .tx_bb_is_ongoing (tx_bb_is_ongoing),
    .pulse_tx_bb_end  (pulse_tx_bb_end),
    .cfg_pa_lead      (cfg_pa_lead),
    .cfg_pa_lag       (cfg_pa_lag),
    .cfg_rx_settle    (cfg_rx_settle),
    .cfg_tx_max       (cfg_tx_max),
    .tx_grant         (tx_grant),
    .tr_sw_tx         (tr_sw_tx),
    .pa_en            (pa_en),
    .rx_blank         (rx_blank),
    .busy             (busy),
    .state            (state),
    .wd_abort         (wd_abort)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit chk_en      = 1'b0;

  // Model: current phase (0 idle,1 lead,2 grant,3 tx,4 lag,5 settle), the
  // cycle number its first cycle occupies and its required length.
  int m_ph    = 0;
  int m_start = 0;
  int m_len   = 0;
  bit m_abort = 1'b0;

  task automatic enter(input int ph, input int len);
    m_ph    = ph;
    m_start = cyc + 1;
    m_len   = len;
  endtask

  // Evaluated at the clock edge that ends cycle 'cyc'.
  task automatic model_update();
    int el;
    el      = cyc - m_start + 1;
    m_abort = 1'b0;
    if (!rstn) begin
      enter(0, 0);
    end else begin
      case (m_ph)
        0: if (tx_req) enter(1, cfg_pa_lead + 1);
        1: begin
          if (!tx_req)         enter(5, cfg_rx_settle + 1);
          else if (el >= m_len) enter(2, 0);
        end
        2: begin
          if (tx_bb_is_ongoing) enter(3, 0);
          else if (!tx_req)     enter(5, cfg_rx_settle + 1);
        end
        3: begin
          if (pulse_tx_bb_end) enter(4, cfg_pa_lag + 1);
          else if (WD && cfg_tx_max != 0 && el == int'(cfg_tx_max)) begin
            enter(4, cfg_pa_lag + 1);
            m_abort = 1'b1;
          end
        end
        4: if (el >= m_len) enter(5, cfg_rx_settle + 1);
        default: if (el >= m_len) enter(0, 0);
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, plus the output invariants.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] e_st;
      logic e_tr, e_pa, e_bl, e_gr;
      e_st = 3'(m_ph);
      e_tr = (m_ph >= 1) && (m_ph <= 4);
      e_pa = (m_ph >= 2) && (m_ph <= 4);
      e_bl = (m_ph != 0);
      e_gr = (m_ph == 2);
      vectors++;
      if (state !== e_st || tr_sw_tx !== e_tr || pa_en !== e_pa || rx_blank !== e_bl ||
          tx_grant !== e_gr || busy !== e_bl || wd_abort !== m_abort) begin
        miscompares++;
        $display("FAIL outputs at cycle %0d: got st=%0d tr=%b pa=%b bl=%b gr=%b busy=%b wd=%b, expected st=%0d tr=%b pa=%b bl=%b gr=%b busy=%b wd=%b",
                 cyc, state, tr_sw_tx, pa_en, rx_blank, tx_grant, busy, wd_abort,
                 e_st, e_tr, e_pa, e_bl, e_gr, e_bl, m_abort);
      end
      vectors++;
      if ((pa_en && !tr_sw_tx) || (tr_sw_tx && !rx_blank) || (tx_grant && state != 3'd2)) begin
        miscompares++;
        $display("FAIL invariant at cycle %0d: got pa=%b tr=%b bl=%b gr=%b st=%0d, expected pa->tr, tr->bl, gr->st2",
                 cyc, pa_en, tr_sw_tx, rx_blank, tx_grant, state);
      end
    end
  end

  initial begin
    int t0;
    rstn = 1'b0; tx_req = 1'b0; tx_bb_is_ongoing = 1'b0; pulse_tx_bb_end = 1'b0;
    cfg_pa_lead = 10'd0; cfg_pa_lag = 10'd0; cfg_rx_settle = 10'd0; cfg_tx_max = 16'd0;

    // Reset state
    step();
    chk_en = 1'b1;
    lit("reset_state", int'(state), 0);
    lit("reset_pa_en", int'(pa_en), 0);
    step();
    rstn = 1'b1;
    step();

    // Reference timeline: lead=3 lag=2 settle=4, with mid-state cfg changes
    cfg_pa_lead = 10'd3; cfg_pa_lag = 10'd2; cfg_rx_settle = 10'd4;
    tx_req = 1'b1; t0 = cyc;
    step();
    lit("tl_tr_sw_tx_t1", int'(tr_sw_tx), 1);
    cfg_pa_lead = 10'd9;
    run_to(t0 + 4);  lit("tl_grant_t4", int'(tx_grant), 0);
    run_to(t0 + 5);  lit("tl_grant_t5", int'(tx_grant), 1); lit("tl_pa_t5", int'(pa_en), 1);
    run_to(t0 + 7);  tx_bb_is_ongoing = 1'b1;
    run_to(t0 + 8);  lit("tl_state_t8", int'(state), 3); lit("tl_grant_t8", int'(tx_grant), 0);
    run_to(t0 + 20); pulse_tx_bb_end = 1'b1;
    step();          pulse_tx_bb_end = 1'b0; tx_bb_is_ongoing = 1'b0; tx_req = 1'b0;
    cfg_pa_lag = 10'd8;
    run_to(t0 + 23); lit("tl_pa_t23", int'(pa_en), 1);
    run_to(t0 + 24); lit("tl_pa_t24", int'(pa_en), 0); lit("tl_tr_t24", int'(tr_sw_tx), 0);
    cfg_rx_settle = 10'd0;
    run_to(t0 + 28); lit("tl_blank_t28", int'(rx_blank), 1);
    run_to(t0 + 29); lit("tl_blank_t29", int'(rx_blank), 0); lit("tl_state_t29", int'(state), 0);

    // All delays zero
    cfg_pa_lead = 10'd0; cfg_pa_lag = 10'd0; cfg_rx_settle = 10'd0;
    step();
    tx_req = 1'b1; t0 = cyc;
    step(); lit("zero_lead", int'(state), 1);
    step(); lit("zero_grant", int'(state), 2);
    tx_bb_is_ongoing = 1'b1;
    step(); lit("zero_tx", int'(state), 3);
    tx_bb_is_ongoing = 1'b0; pulse_tx_bb_end = 1'b1;
    step(); pulse_tx_bb_end = 1'b0; tx_req = 1'b0; lit("zero_lag", int'(state), 4);
    step(); lit("zero_settle", int'(state), 5);
    step(); lit("zero_idle", int'(state), 0);

    // Abort from GRANT after two GRANT cycles
    cfg_pa_lead = 10'd1; cfg_rx_settle = 10'd3;
    tx_req = 1'b1; t0 = cyc;
    run_to(t0 + 3); lit("ab_grant", int'(tx_grant), 1);
    step();         tx_req = 1'b0;
    step();         lit("ab_settle", int'(state), 5); lit("ab_pa", int'(pa_en), 0);
    run_to(t0 + 8); lit("ab_blank_on", int'(rx_blank), 1);
    step();         lit("ab_blank_off", int'(rx_blank), 0);

    // Stray end pulses in IDLE and LEAD, then reset during TX
    pulse_tx_bb_end = 1'b1;
    step(); pulse_tx_bb_end = 1'b0; lit("stray_idle", int'(state), 0);
    cfg_pa_lead = 10'd2; tx_req = 1'b1; t0 = cyc;
    step(); pulse_tx_bb_end = 1'b1;
    step(); pulse_tx_bb_end = 1'b0; lit("stray_lead", int'(state), 1);
    run_to(t0 + 4); tx_bb_is_ongoing = 1'b1;
    step(); lit("rst_pre_pa", int'(pa_en), 1);
    rstn = 1'b0;
    step(); lit("rst_state", int'(state), 0); lit("rst_pa", int'(pa_en), 0);
    lit("rst_outs", int'({tx_grant, tr_sw_tx, rx_blank, busy, wd_abort}), 0);
    rstn = 1'b1; tx_req = 1'b0; tx_bb_is_ongoing = 1'b0;
    step();

    // TX watchdog, limit 100 cycles
    cfg_pa_lead = 10'd0; cfg_pa_lag = 10'd0; cfg_rx_settle = 10'd0; cfg_tx_max = 16'd100;
    tx_req = 1'b1;
    step(); step(); tx_bb_is_ongoing = 1'b1;
    step(); t0 = cyc;
    run_to(t0 + 99);  lit("wd_before", int'(state), 3);
    run_to(t0 + 100); lit("wd_state", int'(state), WD ? 4 : 3); lit("wd_pulse", int'(wd_abort), WD ? 1 : 0);
    tx_req = 1'b0; tx_bb_is_ongoing = 1'b0; pulse_tx_bb_end = 1'b1;
    step(); pulse_tx_bb_end = 1'b0;
    repeat (6) step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (m_ph == 0 && $urandom_range(3) == 0)
        cfg_tx_max = ($urandom_range(2) == 0) ? 16'd0 : 16'($urandom_range(25, 3));
      if ($urandom_range(9) == 0) begin
        cfg_pa_lead   = 10'($urandom_range(5));
        cfg_pa_lag    = 10'($urandom_range(5));
        cfg_rx_settle = 10'($urandom_range(5));
      end
      if ($urandom_range(11) == 0) tx_req = ~tx_req;
      tx_bb_is_ongoing = ($urandom_range(4) == 0) || (tx_bb_is_ongoing && $urandom_range(5) != 0);
      pulse_tx_bb_end  = ($urandom_range(9) == 0);
      rstn             = ($urandom_range(399) != 0);
      step();
    end
    rstn = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_tr_sequencer.md
RF_TR_SEQUENCER -- requirements
Module: rf_tr_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rstn  in  1  synchronous active-low reset.
REQ-002 SHALL have: tx_req  in  1  level request to transmit, from tx control FSM.
REQ-003 SHALL have: tx_bb_is_ongoing  in  1  baseband TX activity (extended level); pulse_tx_bb_end  in  1  one-cycle end of baseband TX.
REQ-004 SHALL have: cfg_pa_lead  in  10  cycles from T/R switch to PA on; cfg_pa_lag  in  10  cycles PA stays on after bb end; cfg_rx_settle  in  10  cycles after T/R return before RX unblanked.
REQ-005 SHALL have: cfg_tx_max  in  16  watchdog limit in cycles (used only with RF_TX_WATCHDOG_EN).
REQ-006 SHALL have outputs: tx_grant  out  1  baseband may start; tr_sw_tx  out  1  T/R switch to TX; pa_en  out  1  PA enable; rx_blank  out  1  RX/AGC blanking; busy  out  1  state!=IDLE; state  out  3  FSM state; wd_abort  out  1  one-cycle watchdog pulse.

Function
REQ-007 SHALL implement states IDLE=0, LEAD=1, GRANT=2, TX=3, LAG=4, SETTLE=5; all outputs registered.
REQ-008 SHALL use one 10-bit down-counter, loaded on state entry with the state's cfg value (registered at entry; mid-state cfg changes ignored).
REQ-009 IDLE: tx_req=1 -> LEAD next cycle, load cfg_pa_lead; tr_sw_tx=1 and rx_blank=1 from the first LEAD cycle.
REQ-010 LEAD: counter==0 -> GRANT; state duration = cfg_pa_lead+1 cycles (value 0 gives 1 cycle).
REQ-011 GRANT: pa_en=1, tx_grant=1; tx_bb_is_ongoing=1 -> TX, tx_grant=0 from the first TX cycle.
REQ-012 TX: pulse_tx_bb_end=1 -> LAG, load cfg_pa_lag; tx_req ignored in TX.
REQ-013 LAG: pa_en held 1; counter==0 -> SETTLE, load cfg_rx_settle; pa_en=0 and tr_sw_tx=0 from the first SETTLE cycle.
REQ-014 SETTLE: rx_blank held 1; counter==0 -> IDLE; rx_blank=0 in IDLE.
REQ-015 tx_req falling in LEAD or GRANT SHALL abort: go to SETTLE directly (pa_en=0, tr_sw_tx=0 next cycle), never assert tx_grant after abort.
REQ-016 tx_req=1 in SETTLE SHALL not shorten SETTLE; a new sequence starts from IDLE the cycle after SETTLE ends if tx_req still 1.
REQ-017 pulse_tx_bb_end outside TX SHALL be ignored; tx_bb_is_ongoing and tx_req=0 arriving together in GRANT: TX wins.
REQ-018 Invariants: pa_en=1 implies tr_sw_tx=1; tr_sw_tx=1 implies rx_blank=1; tx_grant=1 only in GRANT.

Reset
REQ-019 rstn=0 at clk edge SHALL force IDLE, counter=0, all outputs 0, including mid-sequence (PA off immediately next cycle).

Configuration
REQ-020 With RF_TX_WATCHDOG_EN defined: 16-bit counter clears on TX entry, increments each TX cycle; reaching cfg_tx_max in TX -> LAG with wd_abort=1 for one cycle; cfg_tx_max=0 disables watchdog.
REQ-021 Without RF_TX_WATCHDOG_EN: no watchdog logic, wd_abort tied 0, cfg_tx_max unused.

Structure
REQ-022 State encodings and the 10-bit delay width SHALL live in a shared package/header used by xpu blocks.
REQ-023 Single module; watchdog counter may be a sub-module rf_tx_watchdog.

Verification
REQ-024 lead=3, lag=2, settle=4, tx_req at t0, bb on at t0+7, end pulse at t0+20 -> tr_sw_tx t0+1, tx_grant/pa_en t0+5, pa_en off t0+24, rx_blank off t0+29.
REQ-025 All cfg=0 -> LEAD 1 cycle, LAG 1 cycle, SETTLE 1 cycle; invariants hold.
REQ-026 tx_req drops in GRANT after 2 cycles -> SETTLE next cycle, pa_en=0, tx_grant never re-asserts, rx_blank off after settle+1.
REQ-027 rstn=0 during TX with pa_en=1 -> next cycle all outputs 0, state=0.
REQ-028 Watchdog: cfg_tx_max=100, no end pulse -> wd_abort pulse 100 cycles after TX entry, state LAG; without macro stays TX.
REQ-029 Stray pulse_tx_bb_end in IDLE/LEAD -> no state change.
